alu_registered: RTL and testbench

- 32-bit RISC-V style integer ALU with a single registered output stage, used in the CPU execute stage.
- Computes one of ten logic, shift, arithmetic or compare operations on two operands, selected by an enumerated control code.
- Also produces overflow, zero and equal flags.
- The arithmetic core is purely combinational; all outputs are captured on the rising clock edge.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_registered_if.sv | 26 ++
 rtl/add_sub_n.sv | 22 ++
 rtl/alu_registered.sv | 85 ++++++++
 tb/tb_alu_registered.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encoding and logging helper
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    // Mnemonic for log messages; encodings outside the enum report as UNDEF.
    function automatic string alu_control_name(alu_control_t c);
        case (c)
            ALU_AND:  return "AND";
            ALU_OR:   return "OR";
            ALU_XOR:  return "XOR";
            ALU_SLL:  return "SLL";
            ALU_SRL:  return "SRL";
            ALU_SRA:  return "SRA";
            ALU_ADD:  return "ADD";
            ALU_SUB:  return "SUB";
            ALU_SLT:  return "SLT";
            ALU_SLTU: return "SLTU";
            default:  return "UNDEF";
        endcase
    endfunction

endpackage

// File: rtl/alu_registered_if.sv
// rtl/alu_registered_if.sv - operand/control/result bundle for the registered ALU
interface alu_registered_if #(
    parameter int N = 32
);
    import alu_pkg::*;

    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_control_t control;
    logic [N-1:0] result;
    logic         overflow;
    logic         zero;
    logic         equal;

    // The issuing stage drives operands and reads back the registered result.
    modport master (
        output a, b, control,
        input  result, overflow, zero, equal
    );

    modport slave (
        input  a, b, control,
        output result, overflow, zero, equal
    );

endinterface

// File: rtl/add_sub_n.sv
// rtl/add_sub_n.sv - shared N-bit adder/subtractor with carry and signed overflow
module add_sub_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    logic [N-1:0] b_eff;

    // Subtraction is a + ~b + 1, so one adder serves ADD, SUB and both compares.
    assign b_eff = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

    // Signed overflow: both addends agree in sign but the sum does not.
    assign overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/alu_registered.sv
// rtl/alu_registered.sv - 32-bit integer ALU with one registered output stage
module alu_registered
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_registered_if.slave  alu
);

    localparam int SHW = $clog2(N);

    logic [N-1:0]   as_sum;
    logic           as_carry;
    logic           as_ovf;
    logic           as_sub;
    logic [SHW-1:0] shamt;
    logic           slt_bit;
    logic           sltu_bit;
    logic [N-1:0]   result_next;
    logic           overflow_next;

    // Every operation except ADD needs a - b (SUB, SLT, SLTU).
    assign as_sub = (alu.control != ALU_ADD);
    assign shamt  = alu.b[SHW-1:0];

    add_sub_n #(.N(N)) u_add_sub (
        .a        (alu.a),
        .b        (alu.b),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Signed less-than corrects the difference sign for overflow;
    // unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1.
    assign slt_bit  = as_sum[N-1] ^ as_ovf;
    assign sltu_bit = ~as_carry;

    // Result mux; undefined codes fall through to zero with no overflow.
    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (alu.control)
            ALU_AND:  result_next = alu.a & alu.b;
            ALU_OR:   result_next = alu.a | alu.b;
            ALU_XOR:  result_next = alu.a ^ alu.b;
            ALU_SLL:  result_next = alu.a << shamt;
            ALU_SRL:  result_next = alu.a >> shamt;
            ALU_SRA:  result_next = $signed(alu.a) >>> shamt;
            ALU_ADD: begin
                result_next   = as_sum;
                overflow_next = as_ovf;
            end
            ALU_SUB: begin
                result_next   = as_sum;
                overflow_next = as_ovf;
            end
            ALU_SLT:  result_next = {{(N-1){1'b0}}, slt_bit};
            ALU_SLTU: result_next = {{(N-1){1'b0}}, sltu_bit};
            default: begin
                result_next   = '0;
                overflow_next = 1'b0;
            end
        endcase
    end

    // Output stage: capture result and flags each cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu.result   <= '0;
            alu.overflow <= 1'b0;
            alu.zero     <= 1'b0;
            alu.equal    <= 1'b0;
        end else begin
            alu.result   <= result_next;
            alu.overflow <= overflow_next;
            alu.zero     <= (result_next == '0);
            alu.equal    <= (alu.a == alu.b);
        end
    end

endmodule

// File: tb/tb_alu_registered.sv
// tb/tb_alu_registered.sv - table-driven and swept scoreboard bench for alu_registered
module tb_alu_registered;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        ov;
        logic        z;
        logic        eq;
    } exp_t;

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        alu_control_t c;
        exp_t         e;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    string tag_q[$];

    alu_registered_if #(.N(32)) ifc ();

    alu_registered #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .alu (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input alu_control_t c);
        exp_t e;
        int   s;
        s    = int'(b[4:0]);
        e.r  = 32'h0;
        e.ov = 1'b0;
        case (c)
            ALU_AND:  e.r = a & b;
            ALU_OR:   e.r = a | b;
            ALU_XOR:  e.r = a ^ b;
            ALU_SLL:  e.r = a << s;
            ALU_SRL:  e.r = a >> s;
            ALU_SRA:  e.r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            ALU_ADD: begin
                e.r  = a + b;
                e.ov = (a[31] == b[31]) && (e.r[31] != a[31]);
            end
            ALU_SUB: begin
                e.r  = a - b;
                e.ov = (a[31] != b[31]) && (e.r[31] != a[31]);
            end
            ALU_SLT:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
            default:  e.r = 32'h0;
        endcase
        e.z  = (e.r == 32'h0);
        e.eq = (a == b);
        return e;
    endfunction

    // Drive one op on the falling edge, queue its expectation, compare after the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input alu_control_t c,
                         input exp_t e, input string tag);
        exp_t  x;
        string t;
        @(negedge clk);
        ifc.a       = a;
        ifc.b       = b;
        ifc.control = c;
        sb.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        t = tag_q.pop_front();
        check({t, " result"},   ifc.result, x.r);
        check({t, " overflow"}, {31'h0, ifc.overflow}, {31'h0, x.ov});
        check({t, " zero"},     {31'h0, ifc.zero},     {31'h0, x.z});
        check({t, " equal"},    {31'h0, ifc.equal},    {31'h0, x.eq});
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic ov, input logic z, input logic eq);
        exp_t e;
        e.r = r; e.ov = ov; e.z = z; e.eq = eq;
        return e;
    endfunction

    initial begin
        vec_t        vecs[17];
        logic [31:0] corners[7];
        alu_control_t codes[10];
        alu_control_t undef_c;
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD,  mk(32'h8000_0000, 1, 0, 0)};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD,  mk(32'h0000_0000, 0, 1, 0)};
        vecs[2]  = '{32'h8000_0000, 32'h0000_0001, ALU_SUB,  mk(32'h7FFF_FFFF, 1, 0, 0)};
        vecs[3]  = '{32'h1234_5678, 32'h1234_5678, ALU_SUB,  mk(32'h0000_0000, 0, 1, 1)};
        vecs[4]  = '{32'h0000_0001, 32'h0000_001F, ALU_SLL,  mk(32'h8000_0000, 0, 0, 0)};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0004, ALU_SRL,  mk(32'h0800_0000, 0, 0, 0)};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0004, ALU_SRA,  mk(32'hF800_0000, 0, 0, 0)};
        vecs[7]  = '{32'h1234_5678, 32'h0000_0020, ALU_SLL,  mk(32'h1234_5678, 0, 0, 0)};
        vecs[8]  = '{32'h8000_1234, 32'h0000_0000, ALU_SRA,  mk(32'h8000_1234, 0, 0, 0)};
        vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT,  mk(32'h0000_0001, 0, 0, 0)};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_SLTU, mk(32'h0000_0000, 0, 1, 0)};
        vecs[11] = '{32'h8000_0000, 32'h0000_0000, ALU_SLT,  mk(32'h0000_0001, 0, 0, 0)};
        vecs[12] = '{32'h8000_0000, 32'h0000_0000, ALU_SLTU, mk(32'h0000_0000, 0, 1, 0)};
        vecs[13] = '{32'h0000_0003, 32'h0000_0003, ALU_SLT,  mk(32'h0000_0000, 0, 1, 1)};
        vecs[14] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND,  mk(32'h00F0_00F0, 0, 0, 0)};
        vecs[15] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR,   mk(32'hFFF0_FFF0, 0, 0, 0)};
        vecs[16] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_XOR,  mk(32'hFF00_FF00, 0, 0, 0)};

        corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                    32'h8000_0000, 32'h5555_5555, 32'h0000_001F};
        codes   = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                    ALU_SRA, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU};

        // Reset held with live operands: outputs must stay cleared across edges.
        rst         = 1'b1;
        ifc.a       = 32'd5;
        ifc.b       = 32'd5;
        ifc.control = ALU_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset result",   ifc.result, 32'h0);
        check("reset overflow", {31'h0, ifc.overflow}, 32'h0);
        check("reset zero",     {31'h0, ifc.zero},     32'h0);
        check("reset equal",    {31'h0, ifc.equal},    32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset result",   ifc.result, 32'h0000_000A);
        check("post-reset equal",    {31'h0, ifc.equal},    32'h1);
        check("post-reset zero",     {31'h0, ifc.zero},     32'h0);
        check("post-reset overflow", {31'h0, ifc.overflow}, 32'h0);

        // Directed table.
        for (int i = 0; i < 17; i++)
            issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e,
                  $sformatf("vec%0d %s", i, alu_control_name(vecs[i].c)));

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        issue(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, mk(32'h8000_0000, 1, 0, 0), "pre-async");
        #2;
        rst = 1'b1;
        #1;
        check("async result",   ifc.result, 32'h0);
        check("async overflow", {31'h0, ifc.overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ops after reset release: one-cycle latency, no stall.
        issue(32'h0000_0002, 32'h0000_0003, ALU_ADD, mk(32'h0000_0005, 0, 0, 0), "b2b0");
        issue(32'h0000_0002, 32'h0000_0003, ALU_SUB, mk(32'hFFFF_FFFF, 0, 0, 0), "b2b1");

        // Undefined encodings yield a zero result with zero flag set.
        for (int u = 0; u < 3; u++) begin
            undef_c = (u == 0) ? alu_control_t'(4'b0000) :
                      (u == 1) ? alu_control_t'(4'b0100) : alu_control_t'(4'b1001);
            issue(32'h1234_5678, 32'h1234_5678, undef_c, mk(32'h0, 0, 1, 1),
                  $sformatf("undef%0d", u));
        end

        // Corner cross product over every defined code.
        for (int ci = 0; ci < 10; ci++)
            for (int i = 0; i < 7; i++)
                for (int j = 0; j < 7; j++)
                    issue(corners[i], corners[j], codes[ci],
                          model(corners[i], corners[j], codes[ci]),
                          $sformatf("sweep %s %08h %08h", alu_control_name(codes[ci]),
                                    corners[i], corners[j]));

        // Random pairs over every defined code.
        for (int k = 0; k < 25; k++) begin
            ra = $urandom;
            rb = $urandom;
            for (int ci = 0; ci < 10; ci++)
                issue(ra, rb, codes[ci], model(ra, rb, codes[ci]),
                      $sformatf("rand %s %08h %08h", alu_control_name(codes[ci]), ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
